serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b,
      input  diff, borrow_out, busy, done
   );

   modport slave (
      input  start, a, b,
      output diff, borrow_out, busy, done
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first.
// Result and final borrow are registered and only update on entry to DONE.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// SHIFT | processing one bit per cycle, WIDTH cycles total
// DONE  | result valid and freshly loaded; one-cycle done pulse
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] part;
   logic [WIDTH-1:0] diff_q;
   logic             bor;
   logic             borrow_q;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bor_nxt;
   logic             last_bit;

   // Full-subtractor cell on the current LSBs.
   assign d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
   assign bor_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;
   assign bus.busy       = (state == SHIFT);
   assign bus.done       = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; start is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last_bit)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, bit-serial datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         part     <= '0;
         bor      <= 1'b0;
         cnt      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr <= bus.a;
                  b_sr <= bus.b;
                  part <= '0;
                  bor  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               part <= {d_bit, part[WIDTH-1:1]};
               bor  <= bor_nxt;
               cnt  <= cnt + CW'(1);
               // The last bit goes straight into diff so DONE sees the full result.
               if (last_bit) begin
                  diff_q   <= {d_bit, part[WIDTH-1:1]};
                  borrow_q <= bor_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;
   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start for one cycle; returns at the first SHIFT cycle negedge.
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Count negedges (current one is 1) until done; lat = 0 on timeout.
   task automatic wait_done(output int lat, output int busy_cnt, output int stable);
      logic [7:0] d0;
      d0       = bus.diff;
      lat      = 1;
      busy_cnt = 0;
      stable   = 1;
      while (!bus.done && lat < 30) begin
         if (bus.busy) busy_cnt++;
         if (bus.diff !== d0) stable = 0;
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = 0;
   endtask

   task automatic run_vec(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
      int lat, bc, st;
      start_op(av, bv);
      wait_done(lat, bc, st);
      check("latency", lat, 9);
      check("busy_cycles", bc, 8);
      check("diff_stable", st, 1);
      check("diff", bus.diff, ed);
      check("borrow", bus.borrow_out, eb);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("busy_after_done", bus.busy, 0);
   endtask

   logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
   logic [7:0] vb [4] = '{8'h03, 8'h05, 8'hFF, 8'hFF};
   logic [7:0] vd [4] = '{8'h02, 8'hFE, 8'h01, 8'h00};
   logic       vr [4] = '{1'b0,  1'b1,  1'b1,  1'b0};

   initial begin
      int lat, bc, st, seen, ndone, prev_done;
      int done_t[$];
      logic [7:0] ra, rb;
      logic [8:0] rexp;

      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      #1 rst = 1'b1;
      #2;
      check("rst_diff", bus.diff, 0);
      check("rst_borrow", bus.borrow_out, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      for (int i = 0; i < 4; i++) run_vec(va[i], vb[i], vd[i], vr[i]);

      // Start/operand changes during SHIFT and DONE are ignored
      start_op(8'h80, 8'h01);
      repeat (2) @(negedge clk);
      bus.a     = 8'h10;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, bc, st);
      check("ign_done_seen", (lat != 0), 1);
      check("ign_diff", bus.diff, 8'h7F);
      check("ign_borrow", bus.borrow_out, 0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (bus.busy || bus.done) seen = 1;
      end
      check("ign_no_second_op", seen, 0);
      check("ign_diff_hold", bus.diff, 8'h7F);

      // Reset in the middle of an operation
      start_op(8'h09, 8'h04);
      repeat (3) @(negedge clk);
      check("pre_rst_busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_diff", bus.diff, 0);
      check("abort_borrow", bus.borrow_out, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      check("abort_no_done", seen, 0);
      run_vec(8'h09, 8'h04, 8'h05, 1'b0);

      // start held high: back-to-back operations every WIDTH+2 cycles
      @(negedge clk);
      bus.a     = 8'h20;
      bus.b     = 8'h10;
      bus.start = 1'b1;
      prev_done = 0;
      for (int n = 1; n <= 45; n++) begin
         @(negedge clk);
         if (prev_done) begin
            check("cont_idle_busy", bus.busy, 0);
            check("cont_idle_done", bus.done, 0);
         end
         prev_done = bus.done;
         if (bus.done) begin
            done_t.push_back(n);
            check("cont_diff", bus.diff, 8'h10);
            check("cont_done_busy", bus.busy, 0);
         end
      end
      bus.start = 1'b0;
      ndone = done_t.size();
      check("cont_done_count", ndone, 4);
      if (ndone > 0) check("cont_first_done", done_t[0], 9);
      for (int i = 1; i < ndone; i++) check("cont_period", done_t[i] - done_t[i-1], 10);
      wait_done(lat, bc, st);
      check("cont_drain", (lat != 0), 1);
      @(negedge clk);

      // Random pairs against 9-bit reference subtraction
      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rexp = {1'b0, ra} - {1'b0, rb};
         start_op(ra, rb);
         wait_done(lat, bc, st);
         check("rand_latency", lat, 9);
         check("rand_result", {bus.borrow_out, bus.diff}, rexp);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
